// File: rtl/wishbone_dma_pkg.sv
// Shared types and helpers for the single-channel Wishbone DMA copy sequencer.

package wishbone_dma_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      DONE    = 3'd5
   } dma_seq_state_e;

   function automatic int stride_bytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/wishbone_dma_sequencer.sv
// Memory-to-memory copy sequencer driving the wishbone_master_agent command port.
// Optional abort support is compiled in with `define WB_DMA_SEQ_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for go; config latched on accepted go
// RD_REQ  | waiting for agent idle, then issue read at src_cur
// RD_WAIT | read outstanding; capture data on m_done
// WR_REQ  | waiting for agent idle, then issue write at dst_cur
// WR_WAIT | write outstanding; advance pointers/count on m_done
// DONE    | one-cycle completion pulse

module wishbone_dma_sequencer
   import wishbone_dma_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_go,
   input  logic [ADDR_WIDTH-1:0] i_src_addr,
   input  logic [ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [LEN_WIDTH-1:0]  i_len,
`ifdef WB_DMA_SEQ_ABORT_EN
   input  logic                  i_abort,
   output logic                  o_aborted,
`endif
   output logic                  o_busy,
   output logic                  o_done,
   output logic [LEN_WIDTH-1:0]  o_words_done,
   output logic                  m_start,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic                  m_busy,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic                  m_done
);

   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(stride_bytes(DATA_WIDTH));
   localparam logic [LEN_WIDTH-1:0]  ONE_L    = LEN_WIDTH'(1);

   dma_seq_state_e        state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [LEN_WIDTH-1:0]  words_q, words_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  req_abort;
   logic                  wait_abort;

`ifdef WB_DMA_SEQ_ABORT_EN
   logic abort_pend_q, abort_pend_d;
   logic aborted_q, aborted_d;

   assign req_abort  = i_abort;
   assign wait_abort = abort_pend_q | i_abort;
   assign o_aborted  = aborted_q;

   always_comb begin
      abort_pend_d = abort_pend_q;
      aborted_d    = aborted_q;
      case (state_q)
         IDLE: begin
            if (i_go) begin
               abort_pend_d = 1'b0;
               aborted_d    = 1'b0;
            end
         end
         RD_REQ, WR_REQ: begin
            if (i_abort) aborted_d = 1'b1;
         end
         RD_WAIT, WR_WAIT: begin
            if (i_abort) abort_pend_d = 1'b1;
            if (m_done && wait_abort) aborted_d = 1'b1;
         end
         DONE:    abort_pend_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
      end
   end
`else
   assign req_abort  = 1'b0;
   assign wait_abort = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         words_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_go) state_d = (i_len == '0) ? DONE : RD_REQ;
         RD_REQ: begin
            if (req_abort)    state_d = DONE;
            else if (!m_busy) state_d = RD_WAIT;
         end
         RD_WAIT: if (m_done) state_d = wait_abort ? DONE : WR_REQ;
         WR_REQ: begin
            if (req_abort)    state_d = DONE;
            else if (!m_busy) state_d = WR_WAIT;
         end
         WR_WAIT: if (m_done) state_d = (wait_abort || rem_q == ONE_L) ? DONE : RD_REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pointers advance only once the write has landed, so an abort leaves them at the last good word.
   always_comb begin
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      words_d = words_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (i_go) begin
               src_d   = i_src_addr;
               dst_d   = i_dst_addr;
               rem_d   = i_len;
               words_d = '0;
            end
         end
         RD_WAIT: if (m_done) data_d = m_rdata;
         WR_WAIT: begin
            if (m_done) begin
               words_d = words_q + ONE_L;
               src_d   = src_q + STRIDE_A;
               dst_d   = dst_q + STRIDE_A;
               rem_d   = rem_q - ONE_L;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_words_done = words_q;
      m_start      = 1'b0;
      m_we         = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      case (state_q)
         RD_REQ: begin
            o_busy  = 1'b1;
            m_start = !m_busy && !req_abort;
            m_addr  = src_q;
         end
         RD_WAIT: begin
            o_busy = 1'b1;
            m_addr = src_q;
         end
         WR_REQ: begin
            o_busy  = 1'b1;
            m_start = !m_busy && !req_abort;
            m_we    = 1'b1;
            m_addr  = dst_q;
            m_wdata = data_q;
         end
         WR_WAIT: begin
            o_busy  = 1'b1;
            m_we    = 1'b1;
            m_addr  = dst_q;
            m_wdata = data_q;
         end
         DONE:    o_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wishbone_dma_sequencer.sv
// Directed self-checking bench for wishbone_dma_sequencer with a behavioural agent model.

module tb_wishbone_dma_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_go = 1'b0;
   logic [31:0] i_src_addr = '0;
   logic [31:0] i_dst_addr = '0;
   logic [15:0] i_len = '0;
   logic        o_busy, o_done;
   logic [15:0] o_words_done;
   logic        m_start, m_we;
   logic [31:0] m_addr, m_wdata;
   logic        m_busy = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_done = 1'b0;
`ifdef WB_DMA_SEQ_ABORT_EN
   logic        i_abort = 1'b0;
   logic        o_aborted;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int go_cyc = 0;
   logic hold = 1'b0;

   localparam int LAT = 2;
   logic        op_we   [0:31];
   logic [31:0] op_addr [0:31];
   logic [31:0] op_data [0:31];
   int          op_start[0:31];
   int          op_mdone[0:31];
   int          n_ops = 0;

   wishbone_dma_sequencer dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_go         (i_go),
      .i_src_addr   (i_src_addr),
      .i_dst_addr   (i_dst_addr),
      .i_len        (i_len),
`ifdef WB_DMA_SEQ_ABORT_EN
      .i_abort      (i_abort),
      .o_aborted    (o_aborted),
`endif
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_words_done (o_words_done),
      .m_start      (m_start),
      .m_we         (m_we),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_busy       (m_busy),
      .m_rdata      (m_rdata),
      .m_done       (m_done)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc++;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   // Agent model: samples the command on the edge, busy for LAT cycles, then one-cycle done.
   logic        a_start, a_we, a_busy_seen, a_busy;
   logic [31:0] a_addr, a_wdata;
   int          a_cnt = 0;
   int          a_cur = 0;
   initial a_busy = 1'b0;

   always @(posedge i_clk) begin
      a_start     = m_start;
      a_we        = m_we;
      a_addr      = m_addr;
      a_wdata     = m_wdata;
      a_busy_seen = m_busy;
      #1;
      m_done = 1'b0;
      if (!i_rst_n) begin
         a_cnt  = 0;
         a_busy = 1'b0;
      end else if (a_cnt > 0) begin
         a_cnt--;
         if (a_cnt == 0) begin
            a_busy = 1'b0;
            m_done = 1'b1;
            m_rdata = op_we[a_cur] ? 32'h0 : op_data[a_cur];
            op_mdone[a_cur] = cyc;
         end
      end else if (a_start && !a_busy_seen && n_ops < 32) begin
         a_cur = n_ops;
         op_we[a_cur]    = a_we;
         op_addr[a_cur]  = a_addr;
         op_data[a_cur]  = a_we ? a_wdata : rd_model(a_addr);
         op_start[a_cur] = cyc - 1;
         n_ops++;
         a_busy = 1'b1;
         a_cnt  = LAT;
      end
      m_busy = a_busy | hold;
   end

   always @(negedge i_clk) begin
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic do_go(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
      @(negedge i_clk);
      n_ops      = 0;
      done_cnt   = 0;
      i_src_addr = src;
      i_dst_addr = dst;
      i_len      = len;
      i_go       = 1'b1;
      @(negedge i_clk);
      i_go   = 1'b0;
      go_cyc = cyc;
   endtask

   task automatic wait_done(input string name);
      logic seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge i_clk);
         if (o_done) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: o_done never seen within 300 cycles, required a done pulse", name);
      end
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      n_checks++;
      if ({o_busy, o_done, m_start, m_we} !== 4'b0 || o_words_done !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/done/start/we=%b words=%0d, required 0000 and 0",
                  {o_busy, o_done, m_start, m_we}, o_words_done);
      end
      n_checks++;
      if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h wdata=%h, required 0", m_addr, m_wdata);
      end
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0 || m_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b start=%b, required 0 0", o_busy, m_start);
      end
   endtask

   task automatic test_single();
      do_go(32'h1000, 32'h2000, 16'd1);
      n_checks++;
      if (o_busy !== 1'b1 || m_start !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL single_go_latency: busy=%b start=%b we=%b addr=%h, required 1 1 0 00001000",
                  o_busy, m_start, m_we, m_addr);
      end
      wait_done("single");
      n_checks++;
      if (n_ops !== 2 || op_we[0] !== 1'b0 || op_addr[0] !== 32'h1000) begin
         n_fail++;
         $display("FAIL single_read: ops=%0d we0=%b addr0=%h, required 2 0 00001000", n_ops, op_we[0], op_addr[0]);
      end
      n_checks++;
      if (op_we[1] !== 1'b1 || op_addr[1] !== 32'h2000 || op_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL single_write: we=%b addr=%h data=%h, required 1 00002000 deadbeef",
                  op_we[1], op_addr[1], op_data[1]);
      end
      n_checks++;
      if (op_start[1] !== op_mdone[0] + 1) begin
         n_fail++;
         $display("FAIL single_rw_gap: write start cycle %0d, required %0d", op_start[1], op_mdone[0] + 1);
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== op_mdone[1] + 1 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: pulses=%0d at cycle %0d done_now=%b, required 1 at %0d and 0",
                  done_cnt, done_cyc, o_done, op_mdone[1] + 1);
      end
      n_checks++;
      if (o_words_done !== 16'd1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_words: words=%0d busy=%b, required 1 0", o_words_done, o_busy);
      end
   endtask

   task automatic test_multi();
      logic [31:0] exp_wd [4];
      exp_wd = '{32'hDEAD_BEEF, 32'h5A5A_1004, 32'h5A5A_1008, 32'h5A5A_100C};
      do_go(32'h1000, 32'h3000, 16'd4);
      wait_done("multi");
      n_checks++;
      if (n_ops !== 8 || o_words_done !== 16'd4 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL multi_count: ops=%0d words=%0d pulses=%0d, required 8 4 1", n_ops, o_words_done, done_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (op_we[2*i] !== 1'b0 || op_addr[2*i] !== 32'h1000 + 32'(4*i) ||
             op_we[2*i+1] !== 1'b1 || op_addr[2*i+1] !== 32'h3000 + 32'(4*i) ||
             op_data[2*i+1] !== exp_wd[i]) begin
            n_fail++;
            $display("FAIL multi_word%0d: rd we=%b addr=%h wr we=%b addr=%h data=%h, required 0 %h 1 %h %h",
                     i, op_we[2*i], op_addr[2*i], op_we[2*i+1], op_addr[2*i+1], op_data[2*i+1],
                     32'h1000 + 32'(4*i), 32'h3000 + 32'(4*i), exp_wd[i]);
         end
      end
      for (int k = 1; k < 8; k++) begin
         n_checks++;
         if (op_start[k] !== op_mdone[k-1] + 1) begin
            n_fail++;
            $display("FAIL multi_gap%0d: start cycle %0d, required %0d", k, op_start[k], op_mdone[k-1] + 1);
         end
      end
   endtask

   task automatic test_len0();
      do_go(32'h1000, 32'h2000, 16'd0);
      n_checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || m_start !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_done: done=%b busy=%b start=%b, required 1 0 0", o_done, o_busy, m_start);
      end
      repeat (3) @(negedge i_clk);
      n_checks++;
      if (o_done !== 1'b0 || n_ops !== 0 || done_cnt !== 1 || o_words_done !== 16'd0) begin
         n_fail++;
         $display("FAIL len0_quiet: done=%b ops=%0d pulses=%0d words=%0d, required 0 0 1 0",
                  o_done, n_ops, done_cnt, o_words_done);
      end
   endtask

   task automatic test_wrap();
      do_go(32'hFFFF_FFFC, 32'h4000, 16'd2);
      wait_done("wrap");
      n_checks++;
      if (n_ops !== 4 || op_addr[0] !== 32'hFFFF_FFFC || op_addr[2] !== 32'h0 || op_addr[3] !== 32'h4004) begin
         n_fail++;
         $display("FAIL wrap_addr: ops=%0d rd0=%h rd1=%h wr1=%h, required 4 fffffffc 00000000 00004004",
                  n_ops, op_addr[0], op_addr[2], op_addr[3]);
      end
      n_checks++;
      if (op_data[1] !== 32'hA5A5_FFFC || op_data[3] !== 32'h5A5A_0000) begin
         n_fail++;
         $display("FAIL wrap_data: wr0=%h wr1=%h, required a5a5fffc 5a5a0000", op_data[1], op_data[3]);
      end
   endtask

   task automatic test_go_ignored();
      do_go(32'h0100, 32'h0200, 16'd3);
      repeat (4) @(negedge i_clk);
      i_src_addr = 32'h0900;
      i_dst_addr = 32'h0990;
      i_len      = 16'd9;
      i_go       = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      wait_done("go_ignored");
      n_checks++;
      if (n_ops !== 6 || o_words_done !== 16'd3) begin
         n_fail++;
         $display("FAIL go_ignored_len: ops=%0d words=%0d, required 6 3", n_ops, o_words_done);
      end
      n_checks++;
      if (op_addr[4] !== 32'h0108 || op_addr[5] !== 32'h0208) begin
         n_fail++;
         $display("FAIL go_ignored_addr: rd2=%h wr2=%h, required 00000108 00000208", op_addr[4], op_addr[5]);
      end
   endtask

   task automatic test_busy_wait();
      hold = 1'b1;
      @(posedge i_clk);
      do_go(32'h1000, 32'h2000, 16'd1);
      repeat (5) @(negedge i_clk);
      n_checks++;
      if (n_ops !== 0 || o_busy !== 1'b1 || m_start !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_wait_hold: ops=%0d busy=%b start=%b, required 0 1 0", n_ops, o_busy, m_start);
      end
      hold = 1'b0;
      wait_done("busy_wait");
      n_checks++;
      if (n_ops !== 2 || op_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL busy_wait_run: ops=%0d data=%h, required 2 deadbeef", n_ops, op_data[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      do_go(32'h1000, 32'h6000, 16'd2);
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge i_clk);
         if (m_we && m_busy && !m_start) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL rst_mid_reach: WR_WAIT not observed within 50 cycles, required it");
      end
      i_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_busy, o_done, m_start, m_we} !== 4'b0 || o_words_done !== 16'h0 ||
          m_addr !== 32'h0 || m_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: ctl=%b words=%0d addr=%h wdata=%h, required all 0",
                  {o_busy, o_done, m_start, m_we}, o_words_done, m_addr, m_wdata);
      end
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      n_checks++;
      if (done_cnt !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_nodone: pulses=%0d, required 0", done_cnt);
      end
      do_go(32'h1000, 32'h5000, 16'd1);
      wait_done("rst_mid_rerun");
      n_checks++;
      if (n_ops !== 2 || op_addr[1] !== 32'h5000 || op_data[1] !== 32'hDEAD_BEEF || o_words_done !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_mid_rerun: ops=%0d addr=%h data=%h words=%0d, required 2 00005000 deadbeef 1",
                  n_ops, op_addr[1], op_data[1], o_words_done);
      end
   endtask

`ifdef WB_DMA_SEQ_ABORT_EN
   task automatic test_abort();
      logic found = 1'b0;
      do_go(32'h1000, 32'h7000, 16'd4);
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge i_clk);
         if (n_ops == 3 && m_busy && !m_we) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL abort_reach: second read wait not observed, required it");
      end
      i_abort = 1'b1;
      @(negedge i_clk);
      i_abort = 1'b0;
      wait_done("abort");
      n_checks++;
      if (o_words_done !== 16'd1 || o_aborted !== 1'b1 || n_ops !== 3) begin
         n_fail++;
         $display("FAIL abort_result: words=%0d aborted=%b ops=%0d, required 1 1 3", o_words_done, o_aborted, n_ops);
      end
      do_go(32'h1000, 32'h7000, 16'd0);
      n_checks++;
      if (o_aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_clear: aborted=%b, required 0", o_aborted);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_len0();
      test_wrap();
      test_go_ignored();
      test_busy_wait();
      test_reset_mid();
`ifdef WB_DMA_SEQ_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
